mc_control_fsm: RTL and testbench

Multi-cycle MIPS control unit that sequences the shared datapath (ALU, instruction/data memory, register file, PC) one instruction at a time. It decodes `op`/`funct` from the instruction register, steps a Moore state machine through fetch/decode/execute/memory/writeback, and drives every datapath select and enable, including the 3-bit ALU control code. It sits beside the datapath in the multi-cycle top level and is the only source of datapath control.

---
 rtl/mips_ctrl_pkg.sv | 59 +++++
 rtl/alu_decoder.sv | 35 +++
 rtl/mc_control_fsm.sv | 136 +++++++++++++
 tb/tb_mc_control_fsm.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit and the ALU.
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
      EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
   } state_t;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } aluop_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_ANDN = 3'b100;
   localparam logic [2:0] ALU_ORN  = 3'b101;
   localparam logic [2:0] ALU_SUB  = 3'b110;
   localparam logic [2:0] ALU_SLT  = 3'b111;

   // Registered control word; pcwrite/branch/bne only feed the pcen equation.
   typedef struct packed {
      logic       pcwrite;
      logic       branch;
      logic       bne;
      logic       iord;
      logic       memwrite;
      logic       irwrite;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      aluop_t     aluop;
   } ctrl_t;

   function automatic logic isSupportedFunct(input logic [5:0] f);
      return (f == FUNCT_ADD) || (f == FUNCT_SUB) || (f == FUNCT_AND) ||
             (f == FUNCT_OR)  || (f == FUNCT_SLT);
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from the FSM's aluop and the instruction funct field.
module alu_decoder
   import mips_ctrl_pkg::*;
#(
   parameter int CNTRL_WIDTH = 3
) (
   input  aluop_t                 aluop,
   input  logic [5:0]             funct,
   output logic [CNTRL_WIDTH-1:0] alucontrol
);

   logic [2:0] code;

   // Unknown funct falls back to add; DECODE never lets it reach EXECUTE.
   always_comb begin
      code = ALU_ADD;
      case (aluop)
         ALUOP_ADD: code = ALU_ADD;
         ALUOP_SUB: code = ALU_SUB;
         default: begin
            case (funct)
               FUNCT_ADD: code = ALU_ADD;
               FUNCT_SUB: code = ALU_SUB;
               FUNCT_AND: code = ALU_AND;
               FUNCT_OR:  code = ALU_OR;
               FUNCT_SLT: code = ALU_SLT;
               default:   code = ALU_ADD;
            endcase
         end
      endcase
   end

   assign alucontrol = CNTRL_WIDTH'(code);

endmodule

// File: rtl/mc_control_fsm.sv
// Moore control FSM for the multi-cycle MIPS datapath; outputs are registered from the next state.
module mc_control_fsm
   import mips_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH  = 5,
   parameter int CNTRL_WIDTH = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [5:0]             op,
   input  logic [5:0]             funct,
   input  logic                   zero,
   output logic                   pcen,
   output logic                   iord,
   output logic                   memwrite,
   output logic                   irwrite,
   output logic                   regdst,
   output logic                   memtoreg,
   output logic                   regwrite,
   output logic                   alusrca,
   output logic [1:0]             alusrcb,
   output logic [1:0]             pcsrc,
   output logic [CNTRL_WIDTH-1:0] alucontrol
);

   if (DATA_WIDTH < 1 || CNTRL_WIDTH < 3) begin : gBadParams
      $error("mc_control_fsm: DATA_WIDTH must be >= 1 and CNTRL_WIDTH >= 3");
   end

   state_t state_q, state_d;
   ctrl_t  ctrl_q, ctrl_d;

   function automatic ctrl_t decodeState(input state_t s, input logic opIsBne);
      ctrl_t c;
      c = '0;
      c.aluop = ALUOP_ADD;
      case (s)
         FETCH: begin
            c.irwrite = 1'b1;
            c.pcwrite = 1'b1;
            c.alusrcb = 2'b01;
         end
         DECODE: c.alusrcb = 2'b11;
         MEMADR, ADDIEX: begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'b10;
         end
         MEMRD: c.iord = 1'b1;
         MEMWB: begin
            c.memtoreg = 1'b1;
            c.regwrite = 1'b1;
         end
         MEMWR: begin
            c.iord     = 1'b1;
            c.memwrite = 1'b1;
         end
         EXECUTE: begin
            c.alusrca = 1'b1;
            c.aluop   = ALUOP_FUNCT;
         end
         ALUWB: begin
            c.regdst   = 1'b1;
            c.regwrite = 1'b1;
         end
         ADDIWB: c.regwrite = 1'b1;
         BRANCH: begin
            c.alusrca = 1'b1;
            c.aluop   = ALUOP_SUB;
            c.pcsrc   = 2'b01;
            c.branch  = 1'b1;
            c.bne     = opIsBne;
         end
         JUMP: begin
            c.pcsrc   = 2'b10;
            c.pcwrite = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   // Unsupported opcodes and R-type functs retire as NOPs straight from DECODE.
   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH: state_d = DECODE;
         DECODE: begin
            case (op)
               OP_LW, OP_SW:   state_d = MEMADR;
               OP_RTYPE:       state_d = isSupportedFunct(funct) ? EXECUTE : FETCH;
               OP_BEQ, OP_BNE: state_d = BRANCH;
               OP_ADDI:        state_d = ADDIEX;
               OP_J:           state_d = JUMP;
               default:        state_d = FETCH;
            endcase
         end
         MEMADR:  state_d = (op == OP_LW) ? MEMRD : MEMWR;
         MEMRD:   state_d = MEMWB;
         EXECUTE: state_d = ALUWB;
         ADDIEX:  state_d = ADDIWB;
         default: state_d = FETCH;
      endcase
   end

   always_comb begin
      ctrl_d = decodeState(state_d, op == OP_BNE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= FETCH;
         ctrl_q  <= decodeState(FETCH, 1'b0);
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
      end
   end

   alu_decoder #(.CNTRL_WIDTH(CNTRL_WIDTH)) uAluDecoder (
      .aluop      (ctrl_q.aluop),
      .funct      (funct),
      .alucontrol (alucontrol)
   );

   assign pcen     = ctrl_q.pcwrite | (ctrl_q.branch & (zero ^ ctrl_q.bne));
   assign iord     = ctrl_q.iord;
   assign memwrite = ctrl_q.memwrite;
   assign irwrite  = ctrl_q.irwrite;
   assign regdst   = ctrl_q.regdst;
   assign memtoreg = ctrl_q.memtoreg;
   assign regwrite = ctrl_q.regwrite;
   assign alusrca  = ctrl_q.alusrca;
   assign alusrcb  = ctrl_q.alusrcb;
   assign pcsrc    = ctrl_q.pcsrc;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: directed instruction sequences plus randomized instructions
// compared cycle by cycle against a phase-list model of each instruction.
module tb_mc_control_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op, funct;
   logic       zero;
   logic       pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] alucontrol;

   int checkCount = 0;
   int errorCount = 0;

   always #5 clk = ~clk;

   mc_control_fsm #(.DATA_WIDTH(5), .CNTRL_WIDTH(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct      (funct),
      .zero       (zero),
      .pcen       (pcen),
      .iord       (iord),
      .memwrite   (memwrite),
      .irwrite    (irwrite),
      .regdst     (regdst),
      .memtoreg   (memtoreg),
      .regwrite   (regwrite),
      .alusrca    (alusrca),
      .alusrcb    (alusrcb),
      .pcsrc      (pcsrc),
      .alucontrol (alucontrol)
   );

   // Output bundle order: pcen iord memwrite irwrite regdst memtoreg regwrite alusrca alusrcb pcsrc alucontrol
   function automatic logic [14:0] observed();
      return {pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
              alusrcb, pcsrc, alucontrol};
   endfunction

   task automatic checkOutput(input string tag, input logic [14:0] got, input logic [14:0] exp);
      checkCount++;
      if (got !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] functCode(input logic [5:0] f);
      case (f)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         default:   return 3'b010;
      endcase
   endfunction

   function automatic logic [14:0] expVec(input string ph, input logic [5:0] f,
                                          input logic isBne, input logic z);
      logic       ePcen, eIord, eMemw, eIrw, eRegdst, eMemtoreg, eRegw, eSrca;
      logic [1:0] eSrcb, ePcsrc;
      logic [2:0] eAlu;
      {ePcen, eIord, eMemw, eIrw, eRegdst, eMemtoreg, eRegw, eSrca} = '0;
      eSrcb  = 2'b00;
      ePcsrc = 2'b00;
      eAlu   = 3'b010;
      case (ph)
         "FETCH":   begin ePcen = 1'b1; eIrw = 1'b1; eSrcb = 2'b01; end
         "DECODE":  eSrcb = 2'b11;
         "MEMADR", "ADDIEX": begin eSrca = 1'b1; eSrcb = 2'b10; end
         "MEMRD":   eIord = 1'b1;
         "MEMWB":   begin eMemtoreg = 1'b1; eRegw = 1'b1; end
         "MEMWR":   begin eIord = 1'b1; eMemw = 1'b1; end
         "EXECUTE": begin eSrca = 1'b1; eAlu = functCode(f); end
         "ALUWB":   begin eRegdst = 1'b1; eRegw = 1'b1; end
         "ADDIWB":  eRegw = 1'b1;
         "BRANCH":  begin eSrca = 1'b1; ePcsrc = 2'b01; eAlu = 3'b110; ePcen = isBne ? ~z : z; end
         "JUMP":    begin ePcsrc = 2'b10; ePcen = 1'b1; end
         default:   ;
      endcase
      return {ePcen, eIord, eMemw, eIrw, eRegdst, eMemtoreg, eRegw, eSrca, eSrcb, ePcsrc, eAlu};
   endfunction

   // Called at a falling edge while the DUT sits in FETCH; returns at the next FETCH (or after an abort).
   // zeroSel 0/1 forces zero, 2 randomizes it per cycle; abortAt is the phase index to reset in, or -1.
   task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f, input int zeroSel,
                                input int abortAt);
      string ph[$];
      logic  z;
      ph = {"FETCH", "DECODE"};
      case (o)
         6'b100011: ph = {ph, "MEMADR", "MEMRD", "MEMWB"};
         6'b101011: ph = {ph, "MEMADR", "MEMWR"};
         6'b000000: if (f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010})
                       ph = {ph, "EXECUTE", "ALUWB"};
         6'b000100, 6'b000101: ph.push_back("BRANCH");
         6'b001000: ph = {ph, "ADDIEX", "ADDIWB"};
         6'b000010: ph.push_back("JUMP");
         default: ;
      endcase
      for (int i = 0; i < ph.size(); i++) begin
         if (i == 0) begin
            op    = o;
            funct = f;
         end
         z    = (zeroSel == 2) ? 1'($urandom_range(0, 1)) : 1'(zeroSel);
         zero = z;
         #1;
         checkOutput($sformatf("op%b_f%b_%s", o, f, ph[i]), observed(),
                     expVec(ph[i], f, o == 6'b000101, z));
         if (i == abortAt) begin
            #2 reset = 1'b1;
            #1 checkOutput("resetAbort", observed(), expVec("FETCH", f, 1'b0, z));
            @(posedge clk);
            @(negedge clk);
            #1 checkOutput("resetHold", observed(), expVec("FETCH", f, 1'b0, z));
            reset = 1'b0;
            return;
         end
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   logic [5:0] opTab [9] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                             6'b001000, 6'b000010, 6'b111111, 6'b000001};
   logic [5:0] fnTab [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};

   initial begin
      reset = 1'b1;
      op    = 6'b0;
      funct = 6'b0;
      zero  = 1'b0;
      repeat (2) @(negedge clk);
      #1 checkOutput("reset", observed(), expVec("FETCH", 6'b0, 1'b0, 1'b0));
      reset = 1'b0;

      applyStimulus(6'b100011, 6'b000000, 2, -1);
      applyStimulus(6'b000000, 6'b101010, 2, -1);
      applyStimulus(6'b000000, 6'b111111, 2, -1);
      applyStimulus(6'b000100, 6'b000000, 1, -1);
      applyStimulus(6'b000100, 6'b000000, 0, -1);
      applyStimulus(6'b000101, 6'b000000, 1, -1);
      applyStimulus(6'b000101, 6'b000000, 0, -1);
      applyStimulus(6'b101011, 6'b000000, 2, -1);
      applyStimulus(6'b000010, 6'b000000, 2, -1);
      applyStimulus(6'b001000, 6'b000000, 2, -1);
      applyStimulus(6'b000000, 6'b100010, 2, 2);
      applyStimulus(6'b000000, 6'b100100, 2, -1);

      for (int n = 0; n < 80; n++) begin
         logic [5:0] o, f;
         o = opTab[$urandom_range(0, 8)];
         f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fnTab[$urandom_range(0, 5)];
         applyStimulus(o, f, 2, ($urandom_range(0, 15) == 0) ? 1 : -1);
      end
      applyStimulus(6'b000010, 6'b000000, 2, -1);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
